// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// A valid/ready handshake accepts one word per frame, and an internal divider sets the bit period.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic                 din_valid,
    input  logic [DATA_BITS-1:0] din,
    output logic                 din_ready,
    output logic                 tx,
    output logic                 tx_en,
    output logic [3:0]           bit_cnt,
    output logic                 done
);

    localparam int DIV_W      = $clog2(CLKS_PER_BIT);
    localparam int HAS_PAR    = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_BITS = 1 + DATA_BITS + HAS_PAR + STOP_BITS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   par_q, par_d;
    logic                   accept;

    assign din_ready = (state_q == S_IDLE) & sel & ~rst;
    assign accept    = din_valid & din_ready;

    assign tx      = tx_q;
    assign tx_en   = (state_q != S_IDLE);
    assign bit_cnt = bit_cnt_q;
    assign done    = done_q;

    // Parity is computed once at acceptance because the shift register is consumed as bits go out.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        par_d     = par_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d      = 1'b1;
                bit_cnt_d = 4'd0;
                div_d     = '0;
                if (accept) begin
                    state_d = S_START;
                    shift_d = din;
                    par_d   = (^din) ^ (PARITY == 2);
                    tx_d    = 1'b0;
                end
            end
            default: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    case (state_q)
                        S_START: begin
                            state_d   = S_DATA;
                            tx_d      = shift_q[0];
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                        S_DATA: begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_DATA) begin
                                if (HAS_PAR != 0) begin
                                    state_d = S_PARITY;
                                    tx_d    = par_q;
                                end else begin
                                    state_d = S_STOP;
                                    tx_d    = 1'b1;
                                end
                            end else begin
                                tx_d    = shift_q[0];
                                shift_d = shift_q >> 1;
                            end
                        end
                        S_PARITY: begin
                            state_d   = S_STOP;
                            tx_d      = 1'b1;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                        S_STOP: begin
                            tx_d = 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d   = S_IDLE;
                                bit_cnt_d = 4'd0;
                                done_d    = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= 4'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            par_q     <= par_d;
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter replacing the fixed 8N1 control path, with an internal baud divider, configurable data width, parity and stop bits, and a valid/ready input handshake. It sits between a byte/word producer (CPU register, FIFO) and the serial `tx` pin. It serialises one frame per accepted word, LSB first, and signals completion.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: parity mode.
  - 0 = none.
  - 1 = even.
  - 2 = odd.
- `STOP_BITS`, default 1: number of stop bits; 1 or 2.

**Ports**
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sel`  in  1  block enable; when 0, no new frame is accepted.
- `din_valid`  in  1  producer has a word on `din`.
- `din`  in  DATA_BITS  word to send.
- `din_ready`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial line; idles high.
- `tx_en`  out  1  frame in progress.
- `bit_cnt`  out  4  index of the bit currently on `tx`.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation

- **Frame length:** N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- **Frame order:**
  - start bit (0);
  - `din[0]` … `din[DATA_BITS-1]`;
  - optional parity bit;
  - STOP_BITS stop bits (1).
- **Parity value:**
  - even: XOR of all data bits;
  - odd: inverse of that XOR.
- **`bit_cnt` values:**
  - 0 = start;
  - 1..DATA_BITS = data;
  - then parity, if enabled;
  - then stop bit(s).
- **State machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when PARITY=0.
  - STOP lasts STOP_BITS bit periods.
- **Handshake:**
  - `din_ready` = (state==IDLE) & `sel` & ~`rst`; it is combinational from registered state.
  - A word is accepted on an edge where `din_valid` & `din_ready` are both 1.
  - `din` is latched into an internal shift register on acceptance; `din` may change afterwards.
- **Baud divider:**
  - Counts 0..CLKS_PER_BIT-1.
  - Cleared on acceptance, so bit boundaries align to acceptance.
  - The state advances when the count reaches CLKS_PER_BIT-1.
- **`sel` dropped mid-frame:** the current frame completes normally, but no further word is accepted.
- **`rst` mid-frame:** the frame is abandoned immediately; the block returns to the reset state below.
- **Reset values:**
  - `tx`=1, `tx_en`=0, `bit_cnt`=0, `done`=0, `din_ready`=0 while `rst`=1.
  - State = IDLE; divider = 0; shift register = 0.
- **Idle outputs:** `tx`=1, `tx_en`=0, `bit_cnt`=0.

## Timing

- Let C = CLKS_PER_BIT and k = 0 be the first cycle after the acceptance edge.
- Bit i (0 ≤ i < N) drives `tx` for k ∈ [i·C, (i+1)·C−1].
  - `tx` is registered, so there is no glitch between bits.
- `tx_en`=1 and `din_ready`=0 for k ∈ [0, N·C−1].
- At k = N·C: state is IDLE, `done`=1 for exactly this cycle, and `din_ready`=`sel`.
- **Back-to-back:** if `din_valid` is held, the next acceptance is on the edge ending k = N·C. The next start bit begins at k = N·C+1, giving exactly one idle-high cycle between frames.
- **Latency:** acceptance edge → `tx` falling is 1 cycle.
- **Simultaneous `rst` and `din_valid`:** reset wins; the word is not accepted.

## Test plan

- **8N1 byte:** C=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5.
  - `tx` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses at k=40.
  - `bit_cnt` steps 0..9.
- **Parity modes:** C=4, send 0xA5.
  - PARITY=1 (even): parity bit 0.
  - PARITY=2 (odd): parity bit 1.
  - `done` at k=44; `bit_cnt` reaches 10.
- **7 data bits, 2 stop bits:** DATA_BITS=7, STOP_BITS=2, C=3; send 0x41.
  - `tx` = 0,1,0,0,0,0,0,1,1,1.
  - `done` at k=30.
- **Back-to-back with input change:** `din_valid` held high with 0x00 then 0xFF.
  - Exactly one idle-high cycle between frames.
  - `din` is changed during frame 1 with no effect on frame 1.
  - `din_ready` is high only at k=N·C.
- **Enable control:**
  - `sel`=0 with `din_valid`=1: `din_ready`=0, `tx` stays 1, no frame.
  - `sel` dropped at k=10 of a frame: that frame completes, then nothing is accepted.
- **Reset mid-frame:** `rst` pulsed at k=17.
  - Next cycle: `tx`=1, `tx_en`=0, `bit_cnt`=0, `done`=0.
  - After release: a new 0x3C frame transmits correctly from its start bit.
